mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the 16-bit-address, 8-bit-data `memory` block (RAM below 0x8000, I/O at 0x8000 and above). It takes one access at a time from either of two requesters: port 0 is the CPU and port 1 is the loader/debug engine. It drives the memory strobes in the memory's required order: a command cycle with `ce`+`w`/`r`, then for reads an output cycle with `ce`+`oe`. It then returns read data and a one-cycle `ack` to the winning requester.

---
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (0=CPU, 1=loader) arbiter sequencing ce+w/r then ce+oe strobes to memory, acking the winner
module mem_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] addr0,
  input  logic [7:0]  wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata1,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        mem_ce,
  output logic        mem_w,
  output logic        mem_r,
  output logic        mem_oe,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);
  typedef enum logic [1:0] {IDLE, CMD, RD, DONE} state_t;
  state_t      state;
  logic        last, sel, we_l, gnt, g_we;
  logic [15:0] g_addr;
  logic [7:0]  g_wdata;
  always_comb begin
    gnt     = (req0 && req1) ? (RR ? ~last : 1'b0) : req1;
    g_we    = gnt ? we1 : we0;
    g_addr  = gnt ? addr1 : addr0;
    g_wdata = gnt ? wdata1 : wdata0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      we_l      <= 1'b0;
      rdata     <= 8'h00;
      busy      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      mem_ce    <= 1'b0;
      mem_w     <= 1'b0;
      mem_r     <= 1'b0;
      mem_oe    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
    end else begin
      case (state)
        IDLE: if (req0 || req1) begin
          state     <= CMD;
          sel       <= gnt;
          last      <= gnt;
          we_l      <= g_we;
          mem_addr  <= g_addr;
          mem_wdata <= g_wdata;
          mem_ce    <= 1'b1;
          mem_w     <= g_we;
          mem_r     <= ~g_we;
          busy      <= 1'b1;
        end
        CMD: begin
          state  <= we_l ? DONE : RD;
          mem_ce <= ~we_l;
          mem_oe <= ~we_l;
          mem_w  <= 1'b0;
          mem_r  <= 1'b0;
          ack0   <= we_l & ~sel;
          ack1   <= we_l & sel;
        end
        RD: begin
          state  <= DONE;
          rdata  <= mem_rdata;
          mem_ce <= 1'b0;
          mem_oe <= 1'b0;
          ack0   <= ~sel;
          ack1   <= sel;
        end
        DONE: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  logic        clk, rst;
  logic        req0, we0, req1, we1, ack0, ack1, busy;
  logic [15:0] addr0, addr1, mem_addr;
  logic [7:0]  wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic        mem_ce, mem_w, mem_r, mem_oe;
  logic        f_ack0, f_ack1, f_busy, f_ce, f_w, f_r, f_oe;
  logic [15:0] f_addr;
  logic [7:0]  f_rdata, f_wdata, f_mrdata;
  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  int          n_cmp = 0, n_bad = 0, wr_cnt = 0;
  logic [15:0] last_wa;
  logic [7:0]  last_wd;
  bit          act, m_port, m_we, m_last;
  int          ofs, len;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, exp_rd;
  bit          pend [2];
  int          seq [$];
  int          f0_cnt, f1_cnt;
  mem_arbiter #(.RR(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .mem_ce(mem_ce), .mem_w(mem_w), .mem_r(mem_r), .mem_oe(mem_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  mem_arbiter #(.RR(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(f_ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(f_ack1),
    .rdata(f_rdata), .busy(f_busy),
    .mem_ce(f_ce), .mem_w(f_w), .mem_r(f_r), .mem_oe(f_oe),
    .mem_addr(f_addr), .mem_wdata(f_wdata), .mem_rdata(f_mrdata)
  );
  assign mem_rdata = (mem_ce && mem_oe) ? mem[mem_addr] : 8'h00;
  assign f_mrdata  = (f_ce && f_oe) ? mem[f_addr] : 8'h00;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    bit p;
    @(posedge clk);
    if (rst) begin
      act = 0; m_last = 1; m_addr = 0; m_wdata = 0; m_we = 0; exp_rd = 0;
    end else if (act) begin
      ofs++;
      if (ofs == len - 1 && !m_we) exp_rd = ref_mem[m_addr];
      if (ofs == len) act = 0;
    end else if (req0 || req1) begin
      if (req0 && req1) p = m_last ? 1'b0 : 1'b1;
      else p = req1;
      act = 1; ofs = 1; m_port = p; m_last = p;
      m_we    = p ? we1 : we0;
      m_addr  = p ? addr1 : addr0;
      m_wdata = p ? wdata1 : wdata0;
      len     = m_we ? 3 : 4;
      if (m_we) ref_mem[m_addr] = m_wdata;
    end
    #1;
    chk("busy",  busy,   act);
    chk("ce",    mem_ce, act && ofs <= len - 2);
    chk("w",     mem_w,  act && ofs == 1 && m_we);
    chk("r",     mem_r,  act && ofs == 1 && !m_we);
    chk("oe",    mem_oe, act && ofs == 2 && !m_we);
    chk("ack0",  ack0,   act && ofs == len - 1 && !m_port);
    chk("ack1",  ack1,   act && ofs == len - 1 && m_port);
    chk("rdata", rdata,  exp_rd);
    chk("addr",  mem_addr,  m_addr);
    chk("wdata", mem_wdata, m_wdata);
    if (mem_ce && mem_w) begin
      mem[mem_addr] = mem_wdata;
      wr_cnt++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
    end
  endtask
  task automatic drive(input bit p, input bit r, input bit w, input logic [15:0] a, input logic [7:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask
  task automatic xfer(input bit p, input bit w, input logic [15:0] a, input logic [7:0] d, output int n);
    drive(p, 1, w, a, d);
    for (n = 1; n <= 12; n++) begin
      step();
      if (p ? ack1 : ack0) break;
    end
    if (n > 12) chk("ack_timeout", 0, 1);
    drive(p, 0, 0, 0, 0);
    step();
  endtask
  initial begin
    int n, wc;
    logic [7:0] old;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst = 1;
    drive(0, 1, 0, 16'h1234, 8'h00);
    drive(1, 1, 0, 16'h5678, 8'h00);
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_ce, mem_w, mem_r, mem_oe, ack0, ack1}, 0);
    chk("rst_rdata", rdata, 8'h00);
    rst = 0;
    step();
    chk("first_grant", mem_addr, 16'h1234);
    drive(0, 0, 0, 16'h0000, 8'h00);
    for (n = 0; n < 12 && !ack1; n++) step();
    if (!ack1) chk("rst_ack1_timeout", 0, 1);
    drive(1, 0, 0, 16'h0000, 8'h00);
    step();
    wc = wr_cnt;
    xfer(0, 1, 16'h0010, 8'hA5, n);
    chk("wr_lat", n, 2);
    chk("wr_count", wr_cnt - wc, 1);
    chk("wr_mem", mem[16'h0010], 8'hA5);
    xfer(0, 0, 16'h0010, 8'h00, n);
    chk("rd_lat", n, 3);
    chk("rd_data", rdata, 8'hA5);
    wc = wr_cnt;
    xfer(1, 1, 16'h8000, 8'h3F, n);
    chk("io_count", wr_cnt - wc, 1);
    chk("io_addr", last_wa, 16'h8000);
    chk("io_data", last_wd, 8'h3F);
    rst = 1;
    step();
    rst = 0;
    f0_cnt = 0; f1_cnt = 0;
    drive(0, 1, 0, 16'h0001, 8'h00);
    drive(1, 1, 0, 16'h0002, 8'h00);
    for (int c = 0; c < 24; c++) begin
      step();
      if (ack0) seq.push_back(0);
      if (ack1) seq.push_back(1);
      if (f_ack0) begin f0_cnt++; chk("fp_rdata", f_rdata, mem[16'h0001]); end
      if (f_ack1) f1_cnt++;
    end
    chk("rr_count", seq.size() >= 5, 1);
    chk("rr_first", seq[0], 0);
    for (int i = 1; i < seq.size(); i++) chk("rr_alt", seq[i], 1 - seq[i-1]);
    chk("fp_no_ack1", f1_cnt, 0);
    chk("fp_ack0", f0_cnt >= 5, 1);
    drive(0, 0, 0, 16'h0000, 8'h00);
    drive(1, 0, 0, 16'h0000, 8'h00);
    for (int i = 0; i < 10 && (busy || f_busy); i++) step();
    chk("drain", busy, 0);
    drive(0, 1, 0, 16'h0005, 8'h00);
    step();
    drive(0, 0, 0, 16'h0000, 8'h00);
    step();
    chk("mr_in_rd", mem_oe, 1);
    rst = 1;
    step();
    chk("mr_idle", busy, 0);
    chk("mr_ack", ack0, 0);
    chk("mr_rdata", rdata, 8'h00);
    rst = 0;
    step();
    chk("mr_no_late_ack", ack0, 0);
    xfer(0, 0, 16'h0005, 8'h00, n);
    chk("mr_retry", rdata, mem[16'h0005]);
    old = mem[16'h0030];
    drive(0, 1, 1, 16'h0020, 8'h11);
    step();
    drive(0, 1, 1, 16'h0030, 8'h22);
    for (n = 0; n < 12 && !ack0; n++) step();
    if (!ack0) chk("cg_timeout", 0, 1);
    drive(0, 0, 0, 16'h0000, 8'h00);
    step();
    chk("cg_orig", mem[16'h0020], 8'h11);
    chk("cg_untouched", mem[16'h0030], old);
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      for (int q = 0; q < 2; q++) begin
        if (pend[q] && (q == 1 ? ack1 : ack0)) pend[q] = 0;
        if (!pend[q]) begin
          if ($urandom_range(0, 2) != 0) begin
            pend[q] = 1;
            drive(1'(q), 1, 1'($urandom),
                  $urandom_range(0, 1) ? 16'($urandom_range(0, 7)) : (16'h8000 | 16'($urandom_range(0, 3))),
                  8'($urandom));
          end else drive(1'(q), 0, 0, 16'h0000, 8'h00);
        end else if (act && m_port == 1'(q))
          drive(1'(q), 1, 1'($urandom), 16'($urandom), 8'($urandom));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
